// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU micro-sequencer: command/ALUK/state encodings,
// operand-select codes and per-command step counts.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    CMD_ADD  = 3'b000,
    CMD_AND  = 3'b001,
    CMD_NOT  = 3'b010,
    CMD_PASS = 3'b011,
    CMD_SUB  = 3'b100,
    CMD_NEG  = 3'b101,
    CMD_MUL  = 3'b110,
    CMD_OR   = 3'b111
  } cmd_t;

  typedef enum logic [1:0] {
    ALUK_ADD  = 2'b00,
    ALUK_AND  = 2'b01,
    ALUK_NOT  = 2'b10,
    ALUK_PASS = 2'b11
  } aluk_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OPA_A = 2'b00,
    OPA_B = 2'b01,
    OPA_T = 2'b10
  } opa_sel_t;

  typedef enum logic [2:0] {
    OPB_ZERO = 3'b000,
    OPB_A    = 3'b001,
    OPB_B    = 3'b010,
    OPB_T    = 3'b011,
    OPB_T2   = 3'b100,
    OPB_ONE  = 3'b101
  } opb_sel_t;

  typedef enum logic {
    DST_T  = 1'b0,
    DST_T2 = 1'b1
  } dst_t;

  localparam int unsigned STEPS_BASIC = 1;
  localparam int unsigned STEPS_NEG   = 2;
  localparam int unsigned STEPS_SUB   = 3;
  localparam int unsigned STEPS_OR    = 4;

  function automatic int unsigned steps_for(cmd_t c, int unsigned width);
    case (c)
      CMD_NEG: return STEPS_NEG;
      CMD_SUB: return STEPS_SUB;
      CMD_OR:  return STEPS_OR;
      CMD_MUL: return 2 * width;
      default: return STEPS_BASIC;
    endcase
  endfunction

endpackage

// File: rtl/alu_step_rom.sv
// Combinational step table: (cmd, step, multiplier bit) -> ALU operand selects,
// function, destination temp and last-step flag.
module alu_step_rom
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 6
) (
  input  cmd_t             cmd,
  input  logic [CNT_W-1:0] step,
  input  logic             bbit,
  output opa_sel_t         opa_sel,
  output opb_sel_t         opb_sel,
  output aluk_t            aluk,
  output dst_t             dst,
  output logic             last
);

  always_comb begin
    opa_sel = OPA_A;
    opb_sel = OPB_ZERO;
    aluk    = ALUK_PASS;
    dst     = DST_T;
    last    = (step == CNT_W'(steps_for(cmd, WIDTH) - 1));
    case (cmd)
      CMD_NEG: begin
        if (step == '0) begin
          aluk = ALUK_NOT;
        end else begin
          opa_sel = OPA_T;
          opb_sel = OPB_ONE;
          aluk    = ALUK_ADD;
        end
      end
      CMD_SUB: begin
        if (step == '0) begin
          opa_sel = OPA_B;
          aluk    = ALUK_NOT;
        end else if (step == CNT_W'(1)) begin
          opa_sel = OPA_T;
          opb_sel = OPB_ONE;
          aluk    = ALUK_ADD;
        end else begin
          opb_sel = OPB_T;
          aluk    = ALUK_ADD;
        end
      end
      // De Morgan: A|B = ~(~A & ~B), second inverse parked in T2
      CMD_OR: begin
        if (step == '0) begin
          aluk = ALUK_NOT;
        end else if (step == CNT_W'(1)) begin
          opa_sel = OPA_B;
          aluk    = ALUK_NOT;
          dst     = DST_T2;
        end else if (step == CNT_W'(2)) begin
          opa_sel = OPA_T;
          opb_sel = OPB_T2;
          aluk    = ALUK_AND;
        end else begin
          opa_sel = OPA_T;
          aluk    = ALUK_NOT;
        end
      end
      // Shift-and-add, MSB first: even steps double, odd steps conditionally add A
      CMD_MUL: begin
        opa_sel = OPA_T;
        if (!step[0]) begin
          opb_sel = OPB_T;
          aluk    = ALUK_ADD;
        end else if (bbit) begin
          opb_sel = OPB_A;
          aluk    = ALUK_ADD;
        end
      end
      default: begin
        opb_sel = OPB_B;
        aluk    = aluk_t'(cmd[1:0]);
      end
    endcase
  end

endmodule

// File: rtl/alu_microseq.sv
// Multi-cycle sequencer driving an external 4-function ALU to build SUB, NEG,
// OR and MUL, with valid/ready command and result handshakes.
module alu_microseq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_cmd,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [2:0]       res_nzp,
  output logic             busy,
  output logic [WIDTH-1:0] alu_opa,
  output logic [WIDTH-1:0] alu_opb,
  output logic [1:0]       alu_aluk,
  input  logic [WIDTH-1:0] alu_out
);

  state_t           state, next_state;
  cmd_t             cmd_q;
  logic [WIDTH-1:0] a_q, b_q, t_q, t2_q;
  logic [CNT_W-1:0] step_q;
  logic [CNT_W-2:0] bidx;
  logic             bbit;
  opa_sel_t         opa_sel;
  opb_sel_t         opb_sel;
  aluk_t            rom_aluk;
  dst_t             dst;
  logic             last;
  logic [WIDTH-1:0] opa_val, opb_val;

  function automatic logic [2:0] cc_of(logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) return 3'b100;
    else if (v == '0) return 3'b010;
    else return 3'b001;
  endfunction

  // Each multiplier bit spans two steps, MSB first
  assign bidx = (CNT_W-1)'(WIDTH-1) - step_q[CNT_W-1:1];
  assign bbit = b_q[bidx];

  alu_step_rom #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_rom (
    .cmd     (cmd_q),
    .step    (step_q),
    .bbit    (bbit),
    .opa_sel (opa_sel),
    .opb_sel (opb_sel),
    .aluk    (rom_aluk),
    .dst     (dst),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (req_valid) next_state = ST_EXEC;
      ST_EXEC: if (last)      next_state = ST_DONE;
      ST_DONE: if (res_ready) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    case (opa_sel)
      OPA_A:   opa_val = a_q;
      OPA_B:   opa_val = b_q;
      OPA_T:   opa_val = t_q;
      default: opa_val = '0;
    endcase
    case (opb_sel)
      OPB_A:   opb_val = a_q;
      OPB_B:   opb_val = b_q;
      OPB_T:   opb_val = t_q;
      OPB_T2:  opb_val = t2_q;
      OPB_ONE: opb_val = WIDTH'(1);
      default: opb_val = '0;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    res_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE);
    alu_aluk  = ALUK_PASS;
    alu_opa   = '0;
    alu_opb   = '0;
    if (state == ST_EXEC) begin
      alu_aluk = rom_aluk;
      alu_opa  = opa_val;
      alu_opb  = opb_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      cmd_q    <= CMD_ADD;
      t_q      <= '0;
      t2_q     <= '0;
      step_q   <= '0;
      res_data <= '0;
      res_nzp  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            a_q    <= req_a;
            b_q    <= req_b;
            cmd_q  <= cmd_t'(req_cmd);
            t_q    <= '0;
            t2_q   <= '0;
            step_q <= '0;
          end
        end
        ST_EXEC: begin
          step_q <= step_q + CNT_W'(1);
          if (dst == DST_T2) t2_q <= alu_out;
          else               t_q  <= alu_out;
          if (last) begin
            res_data <= alu_out;
            res_nzp  <= cc_of(alu_out);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_microseq.sv
// Scoreboard bench for alu_microseq with a behavioural 4-function ALU attached.
module tb_alu_microseq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_cmd;
  logic [15:0] req_a, req_b;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic [2:0]  res_nzp;
  logic        busy;
  logic [15:0] alu_opa, alu_opb, alu_out;
  logic [1:0]  alu_aluk;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  nzp;
    int          lat;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] aluk_log[$];
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_microseq #(.WIDTH(16), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_nzp   (res_nzp),
    .busy      (busy),
    .alu_opa   (alu_opa),
    .alu_opb   (alu_opb),
    .alu_aluk  (alu_aluk),
    .alu_out   (alu_out)
  );

  always_comb begin
    case (alu_aluk)
      2'b00:   alu_out = alu_opa + alu_opb;
      2'b01:   alu_out = alu_opa & alu_opb;
      2'b10:   alu_out = ~alu_opa;
      default: alu_out = alu_opa;
    endcase
  end

  function automatic logic [15:0] model(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    case (c)
      3'd0: return a + b;
      3'd1: return a & b;
      3'd2: return ~a;
      3'd3: return a;
      3'd4: return a - b;
      3'd5: return 16'd0 - a;
      3'd6: return a * b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15]) return 3'b100;
    if (v == 16'd0) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int steps_of(input logic [2:0] c);
    case (c)
      3'd4: return 3;
      3'd5: return 2;
      3'd6: return 32;
      3'd7: return 4;
      default: return 1;
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic accept_cmd(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    req_cmd = c; req_a = a; req_b = b; req_valid = 1'b1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready cmd=%0d: req_ready=%b expected 1", c, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    e.data = model(c, a, b);
    e.nzp  = nzp_of(e.data);
    e.lat  = steps_of(c) + 1;
    sb.push_back(e);
    aluk_log.delete();
  endtask

  task automatic wait_result(input string tag);
    exp_t e;
    int   k;
    bit   seen = 1'b0;
    for (k = 0; k < 40; k++) begin
      if (res_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      aluk_log.push_back(alu_aluk);
      @(negedge clk);
    end
    n_cmp++;
    if (!seen || sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s result_present: seen=%0d queued=%0d expected seen=1 queued>=1", tag, seen, sb.size());
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (res_data !== e.data) begin
      n_fail++;
      $display("FAIL %s data: got %h expected %h", tag, res_data, e.data);
    end
    n_cmp++;
    if (res_nzp !== e.nzp) begin
      n_fail++;
      $display("FAIL %s nzp: got %b expected %b", tag, res_nzp, e.nzp);
    end
    n_cmp++;
    if (k + 1 != e.lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", tag, k + 1, e.lat);
    end
  endtask

  task automatic run_cmd(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b, input string tag);
    res_ready = 1'b1;
    accept_cmd(c, a, b);
    wait_result(tag);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
    req_cmd = '0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({req_ready, res_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_flags: ready/valid/busy=%b expected 100", {req_ready, res_valid, busy});
    end
    n_cmp++;
    if ({res_data, res_nzp} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_result: data=%h nzp=%b expected 0000/000", res_data, res_nzp);
    end
    n_cmp++;
    if ({alu_aluk, alu_opa, alu_opb} !== {2'b11, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_alu_drive: aluk=%b opa=%h opb=%h expected 11/0000/0000", alu_aluk, alu_opa, alu_opb);
    end
  endtask

  task automatic test_sub;
    logic [5:0] seq;
    res_ready = 1'b1;
    accept_cmd(3'd4, 16'h0005, 16'h0007);
    wait_result("sub_5_7");
    seq = 6'h3f;
    if (aluk_log.size() == 3) seq = {aluk_log[0], aluk_log[1], aluk_log[2]};
    n_cmp++;
    if (seq !== 6'b10_00_00) begin
      n_fail++;
      $display("FAIL sub_aluk_seq: got %b (steps=%0d) expected 100000", seq, aluk_log.size());
    end
    @(negedge clk);
    run_cmd(3'd4, 16'h0000, 16'h0000, "sub_0_0");
  endtask

  task automatic test_mul;
    run_cmd(3'd6, 16'h0003, 16'h0005, "mul_3_5");
    run_cmd(3'd6, 16'h0100, 16'h0100, "mul_overflow");
    run_cmd(3'd6, 16'hFFFF, 16'hFFFF, "mul_ones");
  endtask

  task automatic test_misc_ops;
    run_cmd(3'd7, 16'h00F0, 16'h0F0F, "or");
    run_cmd(3'd5, 16'h8000, 16'h0000, "neg_min");
    run_cmd(3'd0, 16'h7FFF, 16'h0001, "add_ovf");
    run_cmd(3'd2, 16'h00FF, 16'h1234, "not");
    run_cmd(3'd3, 16'h0000, 16'hABCD, "pass_zero");
  endtask

  task automatic test_backpressure;
    logic [15:0] held;
    res_ready = 1'b0;
    accept_cmd(3'd0, 16'h1234, 16'h1111);
    wait_result("bp_add");
    held = res_data;
    for (int i = 0; i < 5; i++) begin
      req_cmd = 3'd4; req_a = 16'h0009; req_b = 16'h0003; req_valid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({res_valid, req_ready, busy} !== 3'b101 || res_data !== held) begin
        n_fail++;
        $display("FAIL bp_stall%0d: valid/ready/busy=%b data=%h expected 101 data=%h",
                 i, {res_valid, req_ready, busy}, res_data, held);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({res_valid, req_ready, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL bp_release: valid/ready/busy=%b expected 010", {res_valid, req_ready, busy});
    end
    accept_cmd(3'd4, 16'h0009, 16'h0003);
    wait_result("bp_next_sub");
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul;
    bit spurious = 1'b0;
    res_ready = 1'b1;
    accept_cmd(3'd6, 16'h1234, 16'h0055);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    n_cmp++;
    if ({req_ready, res_valid, busy, res_nzp} !== 6'b100_000 || res_data !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset_state: ready/valid/busy=%b nzp=%b data=%h expected 100 000 0000",
               {req_ready, res_valid, busy}, res_nzp, res_data);
    end
    for (int i = 0; i < 40; i++) begin
      if (res_valid !== 1'b0) spurious = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (spurious) begin
      n_fail++;
      $display("FAIL mid_reset_discard: res_valid seen=1 expected 0");
    end
    run_cmd(3'd1, 16'hFF00, 16'h0FF0, "and_after_reset");
  endtask

  task automatic test_back_to_back;
    logic [2:0]  c;
    logic [15:0] a, b;
    for (int i = 0; i < 12; i++) begin
      c = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      b = 16'($urandom);
      run_cmd(c, a, b, $sformatf("b2b%0d_cmd%0d", i, c));
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_leftover: queue size %0d expected 0", sb.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sub();
    test_mul();
    test_misc_ops();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
